// File: rtl/wb_pkg.sv
// Shared types and constants for the multi-lane writeback/retire stage.
package wb_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int unsigned WB_PC_W    = 32;
  localparam int unsigned WB_DATA_W  = 32;
  localparam int unsigned WB_ADDR_W  = 5;
  localparam int unsigned WB_ENTRY_W = WB_PC_W + 1 + WB_ADDR_W + WB_DATA_W;

  typedef struct packed {
    logic [WB_PC_W-1:0]   pc;
    logic                 we;
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
  } wb_entry_t;

  // (base + off) mod depth, valid while base < depth and off <= depth
  function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off,
                                           input int unsigned depth);
    int unsigned s;
    s = base + off;
    return (s >= depth) ? s - depth : s;
  endfunction

endpackage

// File: rtl/wb_retire_fifo.sv
// In-order retire queue: up to LANES pushes and WPORTS pops per cycle, entries exposed oldest-first.
module wb_retire_fifo
  import wb_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned WPORTS = 1,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(LANES+1)-1:0]    push_cnt_i,
  input  wb_entry_t [LANES-1:0]         push_data_i,
  input  logic [$clog2(WPORTS+1)-1:0]   pop_cnt_i,
  output logic [$clog2(QDEPTH+1)-1:0]   count_o,
  output wb_entry_t [QDEPTH-1:0]        entries_o
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  wb_entry_t [QDEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Pointer/count update and scatter of pushed entries into consecutive slots
  always_comb begin
    head_d  = PTR_W'(wrap_idx(32'(head_q), 32'(pop_cnt_i), QDEPTH));
    tail_d  = PTR_W'(wrap_idx(32'(tail_q), 32'(push_cnt_i), QDEPTH));
    count_d = count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_cnt_i);
    mem_d   = mem_q;
    for (int i = 0; i < LANES; i++) begin
      for (int s = 0; s < QDEPTH; s++) begin
        if (32'(i) < 32'(push_cnt_i) && wrap_idx(32'(tail_q), 32'(i), QDEPTH) == 32'(s))
          mem_d[s] = push_data_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Rotate storage so entries_o[0] is always the oldest entry
  always_comb begin
    entries_o = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      for (int s = 0; s < QDEPTH; s++) begin
        if (wrap_idx(32'(head_q), 32'(i), QDEPTH) == 32'(s))
          entries_o[i] = mem_q[s];
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_retire_mp.sv
// Multi-lane writeback: retires LANES results/cycle over WPORTS RF ports in program order, overflow queued.
// Optional forwarding lookup enabled by defining WB_RETIRE_FWD_EN; entry field widths come from wb_pkg.
module wb_retire_mp
  import wb_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned WPORTS    = 1,
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned PC_W      = WB_PC_W,
  parameter int unsigned DATA_W    = WB_DATA_W,
  parameter int unsigned ADDR_W    = WB_ADDR_W,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STALL_IDX = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [STALL_W-1:0]                      stall,
  input  logic [LANES*(PC_W+1+ADDR_W+DATA_W)-1:0] mem_to_wb_bus,
  output logic [WPORTS-1:0]                       rf_we,
  output logic [WPORTS*ADDR_W-1:0]                rf_waddr,
  output logic [WPORTS*DATA_W-1:0]                rf_wdata,
  output logic                                    wb_stall_req,
  input  logic [2*ADDR_W-1:0]                     fwd_raddr,
  output logic [1:0]                              fwd_hit,
  output logic [2*DATA_W-1:0]                     fwd_data,
  output logic [WPORTS*PC_W-1:0]                  debug_wb_pc,
  output logic [WPORTS*4-1:0]                     debug_wb_rf_wen,
  output logic [WPORTS*ADDR_W-1:0]                debug_wb_rf_wnum,
  output logic [WPORTS*DATA_W-1:0]                debug_wb_rf_wdata
);

  localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);
  localparam int unsigned PUSH_W = $clog2(LANES + 1);
  localparam int unsigned POP_W  = $clog2(WPORTS + 1);

  wb_entry_t [LANES-1:0]  stg_q, stg_d;
  logic                   stg_v_q, stg_v_d;
  logic [LANES-1:0]       live;
  logic                   stg_fire, hold;

  logic [CNT_W-1:0]       q_count;
  wb_entry_t [QDEPTH-1:0] q_ent;
  wb_entry_t [LANES-1:0]  push_data;
  logic [PUSH_W-1:0]      push_cnt;
  logic [POP_W-1:0]       pop_cnt;

  wb_entry_t [WPORTS-1:0] port_e;
  logic [WPORTS-1:0]      port_we;
  int unsigned            lane_rank [LANES];
  int unsigned            n_live, n_pop, unissued;

  always_comb begin
    for (int l = 0; l < LANES; l++)
      live[l] = stg_v_q && stg_q[l].we && (stg_q[l].waddr != '0);
  end

  // Stage load priority: hold, bubble, load, else drop valid once fired
  always_comb begin
    stg_d   = stg_q;
    stg_v_d = stg_v_q;
    if (hold) begin
      stg_d   = stg_q;
      stg_v_d = 1'b1;
    end else if (stall[STALL_IDX] == STOP && stall[STALL_IDX+1] == NO_STOP) begin
      stg_d   = '0;
      stg_v_d = 1'b0;
    end else if (stall[STALL_IDX] == NO_STOP) begin
      stg_d   = mem_to_wb_bus;
      stg_v_d = 1'b1;
    end else begin
      stg_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q   <= '0;
      stg_v_q <= 1'b0;
    end else begin
      stg_q   <= stg_d;
      stg_v_q <= stg_v_d;
    end
  end

  // Port allocation: queued entries first, then live lanes; the bundle fires only if its overflow fits
  always_comb begin
    int unsigned acc;
    acc = 0;
    for (int l = 0; l < LANES; l++) begin
      lane_rank[l] = acc;
      acc = acc + (live[l] ? 32'd1 : 32'd0);
    end
    n_live   = acc;
    n_pop    = (32'(q_count) < WPORTS) ? 32'(q_count) : WPORTS;
    unissued = (n_live > WPORTS - n_pop) ? n_live - (WPORTS - n_pop) : 32'd0;
    stg_fire = stg_v_q && (unissued <= QDEPTH - 32'(q_count) + n_pop);

    port_e    = '0;
    port_we   = '0;
    push_data = '0;
    for (int p = 0; p < WPORTS; p++) begin
      if (32'(p) < n_pop) begin
        port_e[p]  = q_ent[p];
        port_we[p] = 1'b1;
      end
      for (int l = 0; l < LANES; l++) begin
        if (stg_fire && live[l] && (n_pop + lane_rank[l] == 32'(p))) begin
          port_e[p]  = stg_q[l];
          port_we[p] = 1'b1;
        end
      end
    end
    for (int j = 0; j < LANES; j++) begin
      for (int l = 0; l < LANES; l++) begin
        if (stg_fire && live[l] && (n_pop + lane_rank[l] == WPORTS + 32'(j)))
          push_data[j] = stg_q[l];
      end
    end
    push_cnt = stg_fire ? PUSH_W'(unissued) : '0;
    pop_cnt  = POP_W'(n_pop);
  end

  assign hold = stg_v_q && !stg_fire;

  wb_retire_fifo #(
    .LANES (LANES),
    .WPORTS(WPORTS),
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_cnt_i (push_cnt),
    .push_data_i(push_data),
    .pop_cnt_i  (pop_cnt),
    .count_o    (q_count),
    .entries_o  (q_ent)
  );

  // RF and debug ports; everything forced quiet while reset is asserted
  always_comb begin
    rf_we           = '0;
    rf_waddr        = '0;
    rf_wdata        = '0;
    debug_wb_pc     = '0;
    debug_wb_rf_wen = '0;
    for (int p = 0; p < WPORTS; p++) begin
      rf_we[p] = port_we[p] && !rst;
      debug_wb_rf_wen[p*4 +: 4] = {4{port_we[p] && !rst}};
      if (port_we[p] && !rst) begin
        rf_waddr[p*ADDR_W +: ADDR_W]  = port_e[p].waddr;
        rf_wdata[p*DATA_W +: DATA_W]  = port_e[p].wdata;
        debug_wb_pc[p*PC_W +: PC_W]   = port_e[p].pc;
      end
    end
  end

  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign wb_stall_req      = !rst && ((32'(q_count) > QDEPTH - LANES) || hold);

  logic unused_stall;
  assign unused_stall = ^stall;

`ifdef WB_RETIRE_FWD_EN
  // Later matches override earlier ones, so the youngest in-flight write wins
  always_comb begin
    logic [ADDR_W-1:0] ra;
    fwd_hit  = '0;
    fwd_data = '0;
    for (int k = 0; k < 2; k++) begin
      ra = fwd_raddr[k*ADDR_W +: ADDR_W];
      if (!rst && ra != '0) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (32'(i) < 32'(q_count) && q_ent[i].waddr == ra) begin
            fwd_hit[k] = 1'b1;
            fwd_data[k*DATA_W +: DATA_W] = q_ent[i].wdata;
          end
        end
        for (int l = 0; l < LANES; l++) begin
          if (live[l] && stg_q[l].waddr == ra) begin
            fwd_hit[k] = 1'b1;
            fwd_data[k*DATA_W +: DATA_W] = stg_q[l].wdata;
          end
        end
      end
    end
  end
`else
  assign fwd_hit  = '0;
  assign fwd_data = '0;

  logic unused_fwd;
  assign unused_fwd = ^{fwd_raddr, q_ent};
`endif

endmodule

// File: tb/tb_wb_retire_mp.sv
// Directed bench for wb_retire_mp: a WPORTS=2 and a WPORTS=1 instance sharing clock, reset and stall bus.
module tb_wb_retire_mp;

  localparam int unsigned LW = 70;

`ifdef WB_RETIRE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [5:0] stall;
  logic [2*LW-1:0] bus1, bus2;
  logic [9:0] fwd_raddr1, fwd_raddr2;

  logic [1:0]  rf_we2;
  logic [9:0]  rf_waddr2;
  logic [63:0] rf_wdata2;
  logic        sreq2;
  logic [1:0]  fwd_hit2;
  logic [63:0] fwd_data2;
  logic [63:0] dbg_pc2;
  logic [7:0]  dbg_wen2;
  logic [9:0]  dbg_wnum2;
  logic [63:0] dbg_wdata2;

  logic [0:0]  rf_we1;
  logic [4:0]  rf_waddr1;
  logic [31:0] rf_wdata1;
  logic        sreq1;
  logic [1:0]  fwd_hit1;
  logic [63:0] fwd_data1;
  logic [31:0] dbg_pc1;
  logic [3:0]  dbg_wen1;
  logic [4:0]  dbg_wnum1;
  logic [31:0] dbg_wdata1;

  int n_total = 0;
  int n_bad   = 0;

  int unsigned e_we   [7] = '{1, 1, 1, 1, 1, 1, 0};
  int unsigned e_addr [7] = '{5, 6, 5, 6, 5, 6, 0};
  int unsigned e_data [7] = '{'h50, 'h60, 'h51, 'h61, 'h52, 'h62, 0};
  int unsigned e_sreq [7] = '{0, 0, 0, 1, 0, 0, 0};
  int unsigned e_cnt  [7] = '{0, 1, 2, 3, 2, 1, 0};

  always #5 clk = ~clk;

  wb_retire_mp #(.LANES(2), .WPORTS(2), .QDEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .mem_to_wb_bus(bus2),
    .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2), .wb_stall_req(sreq2),
    .fwd_raddr(fwd_raddr2), .fwd_hit(fwd_hit2), .fwd_data(fwd_data2),
    .debug_wb_pc(dbg_pc2), .debug_wb_rf_wen(dbg_wen2),
    .debug_wb_rf_wnum(dbg_wnum2), .debug_wb_rf_wdata(dbg_wdata2)
  );

  wb_retire_mp #(.LANES(2), .WPORTS(1), .QDEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .mem_to_wb_bus(bus1),
    .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1), .wb_stall_req(sreq1),
    .fwd_raddr(fwd_raddr1), .fwd_hit(fwd_hit1), .fwd_data(fwd_data1),
    .debug_wb_pc(dbg_pc1), .debug_wb_rf_wen(dbg_wen1),
    .debug_wb_rf_wnum(dbg_wnum1), .debug_wb_rf_wdata(dbg_wdata1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] lane(input logic we, input logic [4:0] a, input logic [31:0] d);
    return {32'h100 + 32'(a), we, a, d};
  endfunction

  initial begin
    rst = 1'b1; stall = '0; bus1 = '0; bus2 = '0; fwd_raddr1 = '0; fwd_raddr2 = '0;
    repeat (2) tick();
    check("rst_we1",   64'(rf_we1), 0);
    check("rst_we2",   64'(rf_we2), 0);
    check("rst_sreq1", 64'(sreq1), 0);
    check("rst_wen2",  64'(dbg_wen2), 0);
    check("rst_fwd1",  64'(fwd_hit1), 0);
    rst = 1'b0;

    // Two live lanes, two ports: both retire the cycle after loading
    bus2 = {lane(1'b1, 5'd4, 32'h22), lane(1'b1, 5'd3, 32'h11)};
    tick();
    bus2 = '0;
    check("t1_we",    64'(rf_we2), 64'(2'b11));
    check("t1_waddr", 64'(rf_waddr2), 64'({5'd4, 5'd3}));
    check("t1_wdata", rf_wdata2, {32'h22, 32'h11});
    check("t1_pc",    dbg_pc2, {32'h104, 32'h103});
    check("t1_wen",   64'(dbg_wen2), 64'hFF);
    check("t1_qcnt",  64'(dut2.u_fifo.count_o), 0);
    tick();
    check("t1_idle",  64'(rf_we2), 0);

    // One port, three back-to-back bundles {r5,r6}
    for (int c = 0; c < 7; c++) begin
      bus1 = (c < 3) ? {lane(1'b1, 5'd6, 32'h60 + 32'(c)), lane(1'b1, 5'd5, 32'h50 + 32'(c))} : '0;
      tick();
      check($sformatf("t2_we%0d", c),   64'(rf_we1), 64'(e_we[c]));
      check($sformatf("t2_addr%0d", c), 64'(rf_waddr1), 64'(e_addr[c]));
      check($sformatf("t2_data%0d", c), 64'(rf_wdata1), 64'(e_data[c]));
      check($sformatf("t2_sreq%0d", c), 64'(sreq1), 64'(e_sreq[c]));
      check($sformatf("t2_cnt%0d", c),  64'(dut1.u_fifo.count_o), 64'(e_cnt[c]));
    end

    // Non-live lanes: waddr=0 and we=0
    bus1 = {lane(1'b0, 5'd9, 32'h99), lane(1'b1, 5'd0, 32'h77)};
    tick();
    bus1 = '0;
    check("t3_we",  64'(rf_we1), 0);
    check("t3_wen", 64'(dbg_wen1), 0);
    check("t3_cnt", 64'(dut1.u_fifo.count_o), 0);
    tick();
    check("t3_cnt2", 64'(dut1.u_fifo.count_o), 0);

    // Bubble load, then a bundle held on the bus across a 3-cycle full stall
    bus1 = {lane(1'b0, 5'd0, 32'h0), lane(1'b1, 5'd8, 32'hAA)};
    stall = 6'b01_0000;
    tick();
    check("t4_bubble", 64'(rf_we1), 0);
    stall = '0; bus1 = '0;
    tick();
    check("t4_nor8", 64'(rf_we1), 0);
    bus1 = {lane(1'b1, 5'd10, 32'h10), lane(1'b1, 5'd9, 32'h9)};
    tick();
    check("t4_a_we",   64'(rf_we1), 1);
    check("t4_a_addr", 64'(rf_waddr1), 9);
    stall = 6'b11_0000;
    tick();
    check("t4_b_we",   64'(rf_we1), 1);
    check("t4_b_addr", 64'(rf_waddr1), 10);
    tick();
    check("t4_c_we", 64'(rf_we1), 0);
    tick();
    check("t4_d_we", 64'(rf_we1), 0);
    stall = '0; bus1 = '0;
    tick();
    check("t4_e_we",  64'(rf_we1), 0);
    check("t4_e_cnt", 64'(dut1.u_fifo.count_o), 0);

    // Forwarding: queued r7=1 vs younger stage r7=2
    bus1 = {lane(1'b1, 5'd7, 32'h1), lane(1'b1, 5'd11, 32'h5)};
    tick();
    check("t5_p_addr", 64'(rf_waddr1), 11);
    bus1 = {lane(1'b1, 5'd7, 32'h2), lane(1'b1, 5'd12, 32'h6)};
    fwd_raddr1 = {5'd0, 5'd7};
    tick();
    bus1 = '0;
    check("t5_q_addr", 64'(rf_waddr1), 7);
    check("t5_q_data", 64'(rf_wdata1), 1);
    check("t5_hit",    64'(fwd_hit1), FWD ? 64'(2'b01) : 0);
    check("t5_data",   fwd_data1, FWD ? {32'h0, 32'h2} : 64'h0);
    fwd_raddr1 = {5'd7, 5'd12};
    tick();
    check("t5_r_addr", 64'(rf_waddr1), 12);
    check("t5_r_hit",  64'(fwd_hit1), FWD ? 64'(2'b11) : 0);
    check("t5_r_data", fwd_data1, FWD ? {32'h2, 32'h6} : 64'h0);
    fwd_raddr1 = '0;
    tick();
    check("t5_s_addr", 64'(rf_waddr1), 7);
    check("t5_s_data", 64'(rf_wdata1), 2);
    tick();
    check("t5_t_we",  64'(rf_we1), 0);
    check("t5_t_cnt", 64'(dut1.u_fifo.count_o), 0);

    // Reset with three entries queued
    for (int c = 0; c < 4; c++) begin
      bus1 = (c < 3) ? {lane(1'b1, 5'(14 + 2*c), 32'h70), lane(1'b1, 5'(13 + 2*c), 32'h71)} : '0;
      tick();
    end
    check("t6_cnt3", 64'(dut1.u_fifo.count_o), 3);
    check("t6_sreq", 64'(sreq1), 1);
    rst = 1'b1;
    tick();
    check("t6_rst_cnt", 64'(dut1.u_fifo.count_o), 0);
    check("t6_rst_we",  64'(rf_we1), 0);
    rst = 1'b0;
    tick();
    check("t6_we",   64'(rf_we1), 0);
    check("t6_cnt",  64'(dut1.u_fifo.count_o), 0);
    check("t6_sreq0", 64'(sreq1), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_retire_mp.md
Name: wb_retire_mp

Overview:
- Multi-lane writeback stage for the next-generation pipeline.
- Registers LANES results per cycle from MEM.
- Retires them to a register file with WPORTS write ports, strictly in program order.
- Overflow goes to an in-order retire queue; raises stall requests; exposes forwarding lookup over in-flight writes.

Parameters:
- LANES, 2, results per MEM->WB bundle; lane 0 oldest
- WPORTS, 1, RF write ports; 1 <= WPORTS <= LANES
- QDEPTH, 4, retire queue entries; QDEPTH >= LANES
- PC_W, 32, PC width
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- STALL_W, 6, stall bus width
- STALL_IDX, 4, stall bit owning this stage's input; STALL_IDX < STALL_W-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  pipeline stall bus; Stop=1
- mem_to_wb_bus  in  LANES*(PC_W+1+ADDR_W+DATA_W)  per lane {pc,we,waddr,wdata}; lane 0 in LSBs
- rf_we  out  WPORTS  per-port write enable
- rf_waddr  out  WPORTS*ADDR_W  write addresses
- rf_wdata  out  WPORTS*DATA_W  write data
- wb_stall_req  out  1  backpressure to stall controller
- fwd_raddr  in  2*ADDR_W  two lookup addresses
- fwd_hit  out  2  lookup hit
- fwd_data  out  2*DATA_W  youngest in-flight value
- debug_wb_pc  out  WPORTS*PC_W  PC per port
- debug_wb_rf_wen  out  WPORTS*4  {4{rf_we[p]}}
- debug_wb_rf_wnum  out  WPORTS*ADDR_W  = rf_waddr
- debug_wb_rf_wdata  out  WPORTS*DATA_W  = rf_wdata

Behaviour:
- Stage register stg plus valid bit stg_v. Reset: stg=0, stg_v=0, queue empty. All outputs 0 during and after reset until data arrives.
- hold = stg_v && !stg_fire.
- Load priority:
  - rst
  - else hold: keep stg
  - else stall[STALL_IDX]=Stop && stall[STALL_IDX+1]=NoStop: load bubble (stg=0, stg_v=0)
  - else stall[STALL_IDX]=NoStop: stg<=bus, stg_v<=1
  - else keep stg, stg_v<=0 once fired. A fired bundle is never retired twice.
- Live lane = stg_v && we && waddr!=0. Non-live lanes are discarded.
- Candidate order each cycle: queue entries oldest->newest, then live stg lanes by lane index.
- The first min(WPORTS, count) candidates drive ports 0..; port index follows program order. The RF resolves same-address writes with the highest port winning.
- stg_fire = stg_v && (live lanes not issued) <= (QDEPTH - q_count + queue pops this cycle). On fire, unissued live lanes are pushed to the queue in lane order. Otherwise no stg lane is issued or pushed; the queue still drains.
- Latency: stg loads at edge N; a write on an empty queue appears on rf_* combinationally during cycle N+1.
- wb_stall_req = (q_count > QDEPTH-LANES) || hold. Combinational.
- Queue full: no push occurs. Empty: ports take stg lanes directly. Pointers wrap modulo QDEPTH; count width clog2(QDEPTH+1).
- Forwarding: per lookup, search stg live lanes youngest first, then queue newest->oldest. First match gives hit=1 and data. raddr=0 gives hit=0. Entries issued this cycle still hit.
- Reset mid-drain: queue and stg are discarded; no further writes.

Optional Feature:
- Macro WB_RETIRE_FWD_EN.
  - Defined: forwarding lookup as specified.
  - Undefined: fwd_hit=0 and fwd_data=0 constant; search logic is not built; ports remain.

Decomposition:
- Package wb_pkg holds:
  - Stop/NoStop constants
  - wb_entry_t {pc, we, waddr, wdata}
  - width localparams derived from parameters
- Sub-module wb_retire_fifo: multi-push (<=LANES) / multi-pop (<=WPORTS) circular queue. Exposes count, entry array for the forwarding search, and push/pop counts.

Test Plan:
- LANES=2, WPORTS=2; lanes {r3=0x11, r4=0x22}, no stall -> next cycle rf_we=2'b11, ports r3/r4, q_count stays 0.
- WPORTS=1; three back-to-back bundles, each lanes {r5,r6} -> port writes r5,r6,r5,r6,... in order.
  - wb_stall_req rises when q_count>2.
  - No write is lost; queue drains to 0.
- Lane 1 we=0, lane 0 waddr=0 -> no rf_we, nothing queued, debug_wb_rf_wen=0.
- stall[4]=1, stall[5]=0 -> bubble loaded, rf_we=0. stall[4]=1, stall[5]=1 for 3 cycles -> bundle retired exactly once.
- Queue holds r7=0x1, stg lane 1 r7=0x2; fwd_raddr=r7 -> hit=1, data=0x2. Lookup r0 -> hit=0.
- rst asserted with q_count=3 -> next cycle rf_we=0, q_count=0, wb_stall_req=0.
